// File: rtl/counter_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : counter_sched                                                 |
// | Brief    : Run controller for an 8-bit free counter. Holds the programmed |
// |            period and mode, sequences start/pause/stop, and emits a      |
// |            registered terminal-count tick plus a start-reject pulse.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module counter_sched #(
  parameter int W          = 8,
  parameter int PERIOD_DEF = 9
) (
  input  logic         clk,
  input  logic         res,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_period,
  input  logic         cfg_mode,
  input  logic         start,
  input  logic         pause,
  input  logic         stop,
  output logic [W-1:0] cnt,
  output logic         tick,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [W-1:0] c_period_rst = W'(PERIOD_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] period_q, period_d;
  logic         mode_q, mode_d;
  logic         tick_q, tick_d;
  logic         err_q, err_d;

  logic         w_cfg_acc;
  logic [W-1:0] w_period_eff;
  logic         w_mode_eff;

  // Config handshake and the effective period/mode a same-cycle start would see
  always_comb begin
    cfg_ready    = (state_q == ST_IDLE) || (state_q == ST_DONE);
    w_cfg_acc    = cfg_valid && cfg_ready;
    w_period_eff = w_cfg_acc ? cfg_period : period_q;
    w_mode_eff   = w_cfg_acc ? cfg_mode   : mode_q;
  end

  // Next-state, next-count and pulse generation; stop dominates everywhere
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = w_period_eff;
    mode_d   = w_mode_eff;
    tick_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (start) begin
          if (w_period_eff == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (pause) begin
          state_d = ST_HOLD;
        end else if (cnt_q != period_q) begin
          cnt_d = cnt_q + W'(1);
        end else begin
          // Terminal count: periodic wraps to zero, one-shot parks at period
          tick_d = 1'b1;
          if (mode_q) begin
            cnt_d = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_HOLD: begin
        if (stop) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, count, configuration and pulse registers with synchronous reset
  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= c_period_rst;
      mode_q   <= 1'b0;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
      err_q    <= err_d;
    end
  end

  // Status decode from the state register
  always_comb begin
    busy = (state_q == ST_RUN) || (state_q == ST_HOLD);
    done = (state_q == ST_DONE);
    cnt  = cnt_q;
    tick = tick_q;
    err  = err_q;
  end

endmodule
`default_nettype wire
